// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that shares one valid/ready byte sink between NUM_SRC producers, with a bounded burst per grant.
// Optional ARB_STATS_EN adds saturating transfer and grant counters.

// Per-source ready gating: only the granted source sees the sink's ready.
module stream_rr_arbiter_lane #(
    parameter int IDX_W = 2,
    parameter int LANE  = 0
) (
    input  logic [IDX_W-1:0] grant_idx,
    input  logic             active,
    input  logic             dst_ready,
    output logic             src_ready
);
    assign src_ready = active && (grant_idx == IDX_W'(LANE)) && dst_ready;
endmodule

module stream_rr_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic [DATA_W-1:0]          dst_data,
    output logic                       dst_valid,
    input  logic                       dst_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                xfer_count,
    output logic [15:0]                grant_count
`endif
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                         state, state_nxt;
    logic [IDX_W-1:0]               rr_ptr, rr_nxt, grant_nxt, next_idx, pick_idx;
    logic [7:0]                     beat_cnt, beat_nxt;
    logic                           pick_found, active, xfer;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_vec;

    assign src_vec   = src_data;
    assign active    = (state == GRANT) && !reset;
    assign busy      = (state == GRANT);
    assign dst_data  = src_vec[grant_idx];
    assign dst_valid = active && src_valid[grant_idx];
    assign xfer      = dst_valid && dst_ready;
    assign next_idx  = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        stream_rr_arbiter_lane #(.IDX_W(IDX_W), .LANE(g)) u_lane (
            .grant_idx (grant_idx),
            .active    (active),
            .dst_ready (dst_ready),
            .src_ready (src_ready[g])
        );
    end

    // Scan from the farthest candidate down so the closest one to rr_ptr wins.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            cand = IDX_W'(idx);
            if (src_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_idx;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    beat_nxt  = 8'd0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!src_valid[grant_idx] || (xfer && beat_cnt == LAST_BEAT)) begin
                    state_nxt = IDLE;
                    rr_nxt    = next_idx;
                    beat_nxt  = 8'd0;
                end else if (xfer) begin
                    beat_nxt = beat_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            beat_cnt  <= 8'd0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            grant_idx <= grant_nxt;
            beat_cnt  <= beat_nxt;
        end
    end

`ifdef ARB_STATS_EN
    logic grant_start;
    assign grant_start = (state == IDLE) && pick_found;

    always_ff @(posedge clock) begin
        if (reset) begin
            xfer_count  <= 16'd0;
            grant_count <= 16'd0;
        end else begin
            if (xfer && xfer_count != 16'hFFFF)         xfer_count  <= xfer_count + 16'd1;
            if (grant_start && grant_count != 16'hFFFF) grant_count <= grant_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_stream_rr_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] src_data;
    logic [3:0]  src_valid, src_ready;
    logic [7:0]  dst_data;
    logic        dst_valid, dst_ready;
    logic [1:0]  grant_idx;
    logic        busy;
`ifdef ARB_STATS_EN
    logic [15:0] xfer_count, grant_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    stream_rr_arbiter #(.NUM_SRC(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .dst_data  (dst_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .grant_idx (grant_idx),
        .busy      (busy)
`ifdef ARB_STATS_EN
        ,
        .xfer_count  (xfer_count),
        .grant_count (grant_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       rdy;
        logic       chk_st;
        logic [3:0] e_rdy;
        logic       e_dv;
        logic [7:0] e_data;
        logic [1:0] e_g;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] vld, input logic rdy, input logic cs,
                       input logic [3:0] er, input logic edv, input logic [7:0] ed,
                       input logic [1:0] eg, input logic eb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rdy = rdy; v.chk_st = cs;
        v.e_rdy = er; v.e_dv = edv; v.e_data = ed; v.e_g = eg; v.e_busy = eb;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int hs;
        bit idle_seen;

        reset = 1'b1; src_valid = 4'h0; dst_ready = 1'b1; src_data = 32'hD3C2B1A0;

        // Reset with everything valid, then four full bursts in rotating order.
        add(1, 4'hF, 1, 0, 4'h0, 0, 8'h00, 2'd0, 0);
        add(1, 4'hF, 1, 1, 4'h0, 0, 8'hA0, 2'd0, 0);
        add(0, 4'hF, 1, 1, 4'h0, 0, 8'hA0, 2'd0, 0);
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++)
                add(0, 4'hF, 1, 1, 4'(1 << g), 1, 8'(8'hA0 + 8'h11 * g), 2'(g), 1);
            add(0, 4'hF, 1, 1, 4'h0, 0, 8'(8'hA0 + 8'h11 * g), 2'(g), 0);
        end
        for (int b = 0; b < 4; b++) add(0, 4'hF, 1, 1, 4'h1, 1, 8'hA0, 2'd0, 1);
        add(0, 4'hF, 1, 1, 4'h0, 0, 8'hA0, 2'd0, 0);
        add(0, 4'hF, 1, 1, 4'h2, 1, 8'hB1, 2'd1, 1);
        // Reset mid-burst: outputs gated now, rr_ptr restarts at 0 afterwards.
        add(1, 4'hF, 1, 1, 4'h0, 0, 8'hB1, 2'd1, 1);
        add(0, 4'hF, 1, 1, 4'h0, 0, 8'hA0, 2'd0, 0);
        add(0, 4'hF, 1, 1, 4'h1, 1, 8'hA0, 2'd0, 1);

        @(negedge clock);
        foreach (tbl[i]) begin
            reset = tbl[i].rst; src_valid = tbl[i].vld; dst_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d src_ready", i), src_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d dst_valid", i), dst_valid, tbl[i].e_dv);
            if (tbl[i].chk_st) begin
                chk($sformatf("v%0d dst_data", i), dst_data, tbl[i].e_data);
                chk($sformatf("v%0d grant_idx", i), grant_idx, tbl[i].e_g);
                chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
            end
            tick();
        end

        // Only source 2 valid with A5: three full bursts.
        src_valid = 4'h0; do_reset();
        src_valid = 4'b0100; src_data = 32'hD3A5B1A0; dst_ready = 1'b1;
        #1;
        chk("s2 idle busy", busy, 1'b0);
        tick();
        #1;
        chk("s2 grant_idx", grant_idx, 2'd2);
        chk("s2 dst_data", dst_data, 8'hA5);
        chk("s2 src_ready", src_ready, 4'b0100);
        hs = 0;
        for (int c = 1; c < 15; c++) begin
            #1;
            if (dst_valid && dst_ready) hs++;
            tick();
        end
        src_valid = 4'h0;
        #1;
        chk("s2 beats in 3 bursts", hs, 12);
        chk("s2 idle after bursts", busy, 1'b0);
`ifdef ARB_STATS_EN
        chk("stats xfer_count", xfer_count, 16'd12);
        chk("stats grant_count", grant_count, 16'd3);
`endif

        // Source 1 stalled by dst_ready=0 for 10 cycles, then released.
        src_data = 32'hD3C2B1A0; do_reset();
        src_valid = 4'b0010; dst_ready = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("stall%0d busy", c), busy, 1'b1);
            chk($sformatf("stall%0d grant_idx", c), grant_idx, 2'd1);
            chk($sformatf("stall%0d src_ready", c), src_ready, 4'h0);
            tick();
        end
        dst_ready = 1'b1;
        hs = 0; idle_seen = 1'b0;
        for (int c = 0; c < 10 && !idle_seen; c++) begin
            #1;
            if (!busy) idle_seen = 1'b1;
            else begin
                if (dst_valid && dst_ready) hs++;
                tick();
            end
        end
        chk("stall release beats", hs, 4);
        chk("stall release idle reached", idle_seen, 1'b1);

        // Source 3 drops valid after two beats; rr_ptr wraps to 0.
        src_valid = 4'h0; do_reset();
        src_valid = 4'b1000; dst_ready = 1'b1;
        tick();
        #1;
        chk("drop grant_idx", grant_idx, 2'd3);
        chk("drop busy", busy, 1'b1);
        tick();
        tick();
        src_valid = 4'b0111;
        #1;
        chk("drop dst_valid", dst_valid, 1'b0);
        chk("drop still busy", busy, 1'b1);
        tick();
        #1;
        chk("drop idle busy", busy, 1'b0);
        tick();
        #1;
        chk("drop next grant_idx", grant_idx, 2'd0);
        chk("drop next busy", busy, 1'b1);
        chk("drop next dst_data", dst_data, 8'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
